// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 key schedule engine.
package aes_pkg;

   localparam int NUM_WORDS  = 44;
   localparam int NUM_ROUNDS = 10;

   localparam logic [5:0] LAST_WORD = 6'd43;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_EXPAND = 2'd2,
      ST_DONE   = 2'd3
   } ks_state_e;

   // Entry 0 is unused; round constants are indexed by i/4 = 1..10.
   localparam logic [10:0][7:0] RCON = {
      8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
      8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00
   };

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: GF(2^8) multiplicative inverse followed by the affine map.
module aes_sbox (
   input  logic [7:0] in_byte,
   output logic [7:0] out_byte
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] aa;
      acc = 8'h00;
      aa  = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) begin
            acc = acc ^ aa;
         end else begin
            acc = acc;
         end
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return acc;
   endfunction

   // x^254 is the inverse for x != 0 and maps 0 to 0, as the S-box requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
      x2   = gf_mul(x, x);
      x3   = gf_mul(x2, x);
      x6   = gf_mul(x3, x3);
      x12  = gf_mul(x6, x6);
      x15  = gf_mul(x12, x3);
      x30  = gf_mul(x15, x15);
      x60  = gf_mul(x30, x30);
      x120 = gf_mul(x60, x60);
      x240 = gf_mul(x120, x120);
      x252 = gf_mul(x240, x12);
      return gf_mul(x252, x2);
   endfunction

   function automatic logic [7:0] affine(input logic [7:0] b);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   always_comb begin
      out_byte = affine(gf_inv(in_byte));
   end

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key expansion, one schedule word per clock, with START/DONE handshake.
// Build option AES_KEYSCHED_DECRYPT_ORDER_EN reverses round key indexing (10 - RK_INDEX).
module aes_key_schedule
   import aes_pkg::*;
(
   input  logic         CLK,
   input  logic         RESET_N,
   input  logic         START,
   input  logic [127:0] CIPHER_KEY,
   input  logic [3:0]   RK_INDEX,
   output logic         BUSY,
   output logic         DONE,
   output logic [127:0] ROUND_KEY
);

   ks_state_e    state_q, state_d;
   logic [5:0]   idx_q, idx_d;
   logic [31:0]  sched_q [NUM_WORDS];
   logic [31:0]  sched_d [NUM_WORDS];
   logic [127:0] rk_q, rk_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;

   logic [5:0]   cur_idx_s;
   logic [31:0]  prev_s, back_s, rot_s, sub_s, temp_s, new_word_s;
   logic [3:0]   sel_s;
   logic         sel_ok_s;
   logic [5:0]   rd_base_s;

   // Next schedule word; index clamped so reads stay in range outside EXPAND
   always_comb begin
      if (idx_q >= 6'd4) begin
         cur_idx_s = idx_q;
      end else begin
         cur_idx_s = 6'd4;
      end
      prev_s = sched_q[cur_idx_s - 6'd1];
      back_s = sched_q[cur_idx_s - 6'd4];
      rot_s  = {prev_s[23:0], prev_s[31:24]};
      if (cur_idx_s[1:0] == 2'b00) begin
         temp_s = sub_s ^ {RCON[cur_idx_s[5:2]], 24'h000000};
      end else begin
         temp_s = prev_s;
      end
      new_word_s = back_s ^ temp_s;
   end

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (
         .in_byte  (rot_s[8*b +: 8]),
         .out_byte (sub_s[8*b +: 8])
      );
   end

   // Sequencing and schedule writes
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      sched_d = sched_q;
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               state_d = ST_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            sched_d[0] = CIPHER_KEY[127:96];
            sched_d[1] = CIPHER_KEY[95:64];
            sched_d[2] = CIPHER_KEY[63:32];
            sched_d[3] = CIPHER_KEY[31:0];
            idx_d      = 6'd4;
            state_d    = ST_EXPAND;
         end
         ST_EXPAND: begin
            sched_d[idx_q] = new_word_s;
            if (idx_q == LAST_WORD) begin
               state_d = ST_DONE;
            end else begin
               idx_d = idx_q + 6'd1;
            end
         end
         ST_DONE: begin
            if (!START) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_LOAD) || (state_d == ST_EXPAND);
      done_d = (state_d == ST_DONE);
   end

   // Round key readout; out-of-range indices yield zero
   always_comb begin
`ifdef AES_KEYSCHED_DECRYPT_ORDER_EN
      sel_s = 4'd10 - RK_INDEX;
`else
      sel_s = RK_INDEX;
`endif
      sel_ok_s = (RK_INDEX <= 4'd10);
      if (sel_ok_s) begin
         rd_base_s = {sel_s, 2'b00};
         rk_d = {sched_q[rd_base_s], sched_q[rd_base_s + 6'd1],
                 sched_q[rd_base_s + 6'd2], sched_q[rd_base_s + 6'd3]};
      end else begin
         rd_base_s = 6'd0;
         rk_d      = 128'h0;
      end
   end

   // Control and output registers
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= ST_IDLE;
         idx_q   <= 6'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rk_q    <= 128'h0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         rk_q    <= rk_d;
      end
   end

   // Schedule storage
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int k = 0; k < NUM_WORDS; k++) begin
            sched_q[k] <= 32'h0;
         end
      end else begin
         for (int k = 0; k < NUM_WORDS; k++) begin
            sched_q[k] <= sched_d[k];
         end
      end
   end

   assign BUSY      = busy_q;
   assign DONE      = done_q;
   assign ROUND_KEY = rk_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Randomized self-checking bench for aes_key_schedule against a behavioural key expansion model.
module tb_aes_key_schedule;

   logic         CLK;
   logic         RESET_N;
   logic         START;
   logic [127:0] CIPHER_KEY;
   logic [3:0]   RK_INDEX;
   logic         BUSY;
   logic         DONE;
   logic [127:0] ROUND_KEY;

   int n_checks;
   int n_errors;

   logic [7:0]  sb [256];
   logic [31:0] mw [44];

   localparam logic [127:0] KEY_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_R0   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] KEY_SEQ   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] SEQ_R10   = 128'h13111d7fe3944a17f307a78b4d2b30c5;

   aes_key_schedule dut (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .START      (START),
      .CIPHER_KEY (CIPHER_KEY),
      .RK_INDEX   (RK_INDEX),
      .BUSY       (BUSY),
      .DONE       (DONE),
      .ROUND_KEY  (ROUND_KEY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
      logic [15:0] d;
      d = {v, v} << s;
      return d[15:8];
   endfunction

   // S-box by walking the multiplicative group with generator 3 and its inverse
   task automatic build_sbox();
      logic [7:0] p, q;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ (q << 1);
         q = q ^ (q << 2);
         q = q ^ (q << 4);
         if (q[7]) q = q ^ 8'h09;
         sb[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
      end while (p != 8'h01);
      sb[0] = 8'h63;
   endtask

   task automatic model_expand(input logic [127:0] key);
      logic [31:0] t;
      logic [7:0]  rc;
      mw[0] = key[127:96];
      mw[1] = key[95:64];
      mw[2] = key[63:32];
      mw[3] = key[31:0];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = mw[i-1];
         if (i % 4 == 0) begin
            t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
            rc = (rc << 1) ^ (rc[7] ? 8'h1b : 8'h00);
         end
         mw[i] = mw[i-4] ^ t;
      end
   endtask

   function automatic logic [127:0] exp_rk(input int idx);
      int r;
      if (idx > 10) return 128'h0;
`ifdef AES_KEYSCHED_DECRYPT_ORDER_EN
      r = 10 - idx;
`else
      r = idx;
`endif
      return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
   endfunction

   task automatic read_rk(input int idx, output logic [127:0] val);
      @(negedge CLK);
      RK_INDEX = idx[3:0];
      @(posedge CLK);
      @(negedge CLK);
      val = ROUND_KEY;
   endtask

   task automatic check_rk_model(input int idx);
      logic [127:0] v;
      read_rk(idx, v);
      check($sformatf("rk_idx%0d", idx), v, exp_rk(idx));
   endtask

   task automatic check_rk_const(input int idx, input logic [127:0] expv, input string tag);
      logic [127:0] v;
      read_rk(idx, v);
      check(tag, v, expv);
   endtask

   // Start a run and follow it to DONE; optionally scramble key/START once LOAD is over
   task automatic run_expand(input logic [127:0] key, input bit disturb);
      int  n;
      bit  seen;
      @(negedge CLK);
      START = 1'b0;
      @(negedge CLK);
      CIPHER_KEY = key;
      START = 1'b1;
      @(posedge CLK);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 60) begin
         @(negedge CLK);
         check("busy_done_excl", {127'h0, BUSY & DONE}, 128'h0);
         if (DONE) begin
            seen = 1'b1;
            check("done_latency", n, 41);
         end else begin
            check("busy_in_run", {127'h0, BUSY}, 128'h1);
            if (disturb && n >= 1 && n < 38) begin
               CIPHER_KEY = {$urandom, $urandom, $urandom, $urandom};
               START = 1'($urandom_range(0, 1));
            end else if (n >= 1) begin
               START = 1'b1;
            end
            @(posedge CLK);
            n++;
         end
      end
      if (!seen) check("done_timeout", n, 41);
   endtask

   task automatic check_all_rk();
      for (int idx = 0; idx < 16; idx++) check_rk_model(idx);
   endtask

   initial begin
      logic [127:0] k;
      n_checks   = 0;
      n_errors   = 0;
      RESET_N    = 1'b0;
      START      = 1'b0;
      CIPHER_KEY = 128'h0;
      RK_INDEX   = 4'd0;
      build_sbox();

      repeat (2) @(negedge CLK);
      check("rst_busy", {127'h0, BUSY}, 128'h0);
      check("rst_done", {127'h0, DONE}, 128'h0);
      check("rst_rk", ROUND_KEY, 128'h0);
      RESET_N = 1'b1;
      check_rk_model(3 + 0 * 0);
      check("rst_rk_after", ROUND_KEY, 128'h0);

      // FIPS-197 reference key, START held
      model_expand(KEY_FIPS);
      run_expand(KEY_FIPS, 1'b0);
`ifdef AES_KEYSCHED_DECRYPT_ORDER_EN
      check_rk_const(0, FIPS_R10, "fips_idx0");
      check_rk_const(9, FIPS_R1, "fips_idx9");
      check_rk_const(10, FIPS_R0, "fips_idx10");
`else
      check_rk_const(0, FIPS_R0, "fips_idx0");
      check_rk_const(1, FIPS_R1, "fips_idx1");
      check_rk_const(10, FIPS_R10, "fips_idx10");
`endif
      check_rk_const(12, 128'h0, "fips_idx12");
      check_all_rk();

      repeat (3) begin
         @(negedge CLK);
         check("done_held", {126'h0, BUSY, DONE}, 128'h1);
      end
      START = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      check("done_drop", {126'h0, BUSY, DONE}, 128'h0);
      check_rk_model($urandom_range(0, 10));

      // Key changes and START toggles during EXPAND must be ignored
      run_expand(KEY_FIPS, 1'b1);
      check_all_rk();

      // Reset in the middle of EXPAND
      k = {$urandom, $urandom, $urandom, $urandom};
      @(negedge CLK);
      START = 1'b0;
      @(negedge CLK);
      CIPHER_KEY = k;
      START = 1'b1;
      @(posedge CLK);
      @(posedge CLK);
      repeat (20) @(posedge CLK);
      @(negedge CLK);
      RESET_N = 1'b0;
      #1;
      check("midrst_busy", {127'h0, BUSY}, 128'h0);
      check("midrst_done", {127'h0, DONE}, 128'h0);
      check("midrst_rk", ROUND_KEY, 128'h0);
      @(negedge CLK);
      RESET_N = 1'b1;
      START = 1'b0;
      repeat (3) begin
         @(negedge CLK);
         check("midrst_idle", {126'h0, BUSY, DONE}, 128'h0);
      end
      check_rk_const(0, 128'h0, "midrst_sched0");
      check_rk_const(10, 128'h0, "midrst_sched10");
      model_expand(k);
      run_expand(k, 1'b0);
      check_all_rk();

      // Sequential key
      model_expand(KEY_SEQ);
      run_expand(KEY_SEQ, 1'b0);
`ifdef AES_KEYSCHED_DECRYPT_ORDER_EN
      check_rk_const(0, SEQ_R10, "seq_r10");
`else
      check_rk_const(10, SEQ_R10, "seq_r10");
`endif
      check_all_rk();

      // Random keys with random disturbance and random index reads
      repeat (4) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         model_expand(k);
         run_expand(k, 1'($urandom_range(0, 1)));
         repeat (8) check_rk_model($urandom_range(0, 15));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
